// File: rtl/mem_responder.sv
// mem_responder: MEM-interface responder driving an asynchronous 16-bit SRAM.
// Four-phase rqm_n/akm_n handshake; request fields are captured at accept so the
// initiator may change them freely during the access. WAIT_STATES (0..15) adds
// extra ACCESS cycles beyond the first.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a fresh request (rqm_n=1 while akm_n=0)
// SETUP  | address (and write data) presented, ce high, oe high for reads
// ACCESS | strobe active for WAIT_STATES+1 cycles; read data sampled at the end
// HOLD   | writes only: we dropped, addr/dout held for data hold time
// ACK    | strobes off; akm_n follows rqm_n until the initiator releases
module mem_responder #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rqm_n,
  input  logic              rwm_n,
  input  logic [ADDR_W-1:0] adm_n,
  input  logic [DATA_W-1:0] dwm_n,
  output logic              akm_n,
  output logic [DATA_W-1:0] drm_n,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce,
  output logic              sram_oe,
  output logic              sram_we
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_ACK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_beat;
  logic             ce_nxt;
  logic             oe_nxt;
  logic             we_nxt;
  logic             akm_nxt;

  // akm_n gates the accept, so a request held high through the ack cannot re-trigger
  assign accept    = (state == S_IDLE) && rqm_n && !akm_n;
  assign last_beat = (state == S_ACCESS) && (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (cnt == '0) state_nxt = wr_q ? S_HOLD : S_ACK;
      S_HOLD:   state_nxt = S_ACK;
      S_ACK:    if (!rqm_n) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so every pin is a flop output
  always_comb begin
    ce_nxt  = 1'b0;
    oe_nxt  = 1'b0;
    we_nxt  = 1'b0;
    akm_nxt = 1'b0;
    case (state_nxt)
      // SETUP is only entered from IDLE on accept, so rwm_n is the live request
      S_SETUP: begin
        ce_nxt = 1'b1;
        oe_nxt = !rwm_n;
      end
      S_ACCESS: begin
        ce_nxt = 1'b1;
        oe_nxt = !wr_q;
        we_nxt = wr_q;
      end
      S_HOLD:  ce_nxt = 1'b1;
      // an abandoned request (rqm_n already low) enters ACK with akm_n low and leaves
      S_ACK:   akm_nxt = rqm_n;
      default: ;
    endcase
  end

  // Registered strobes, handshake and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_ce <= 1'b0;
      sram_oe <= 1'b0;
      sram_we <= 1'b0;
      akm_n   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      sram_ce <= ce_nxt;
      sram_oe <= oe_nxt;
      sram_we <= we_nxt;
      akm_n   <= akm_nxt;
      busy    <= (state_nxt != S_IDLE);
    end
  end

  // Request capture, wait-state down-counter and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_dout <= '0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      drm_n     <= '0;
    end else begin
      if (accept) begin
        sram_addr <= adm_n;
        wr_q      <= rwm_n;
        cnt       <= CNT_W'(WAIT_STATES);
        if (rwm_n) sram_dout <= dwm_n;
      end else if ((state == S_ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (last_beat && !wr_q) drm_n <= sram_din;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=2 and 0), each with its own
// behavioural SRAM, driven by directed and randomized transactions and compared
// against a shadow memory and latency formulas.
module tb_mem_responder;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rqm   [2];
  logic          rwm   [2];
  logic [AW-1:0] adm   [2];
  logic [DW-1:0] dwm   [2];
  logic          akm   [2];
  logic [DW-1:0] drm   [2];
  logic          busy  [2];
  logic [AW-1:0] saddr [2];
  logic [DW-1:0] sdout [2];
  logic [DW-1:0] sdin  [2];
  logic          ce    [2];
  logic          oe    [2];
  logic          we    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES((g == 0) ? 2 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .rqm_n(rqm[g]), .rwm_n(rwm[g]), .adm_n(adm[g]),
      .dwm_n(dwm[g]), .akm_n(akm[g]), .drm_n(drm[g]), .busy(busy[g]),
      .sram_addr(saddr[g]), .sram_dout(sdout[g]), .sram_din(sdin[g]),
      .sram_ce(ce[g]), .sram_oe(oe[g]), .sram_we(we[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [AW:0] key(input int d, input logic [AW-1:0] a);
    return {(d != 0), a};
  endfunction

  // SRAM model plus strobe-rule monitor
  logic [DW-1:0] mem [logic [AW:0]];
  int            overlap_cnt  = 0;
  int            addr_chg_cnt = 0;
  int            ce_low_run [2] = '{100, 100};
  int            last_gap   [2] = '{100, 100};
  logic          prev_ce    [2] = '{1'b0, 1'b0};
  logic [AW-1:0] prev_addr  [2] = '{'0, '0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      assert (!(oe[g] && we[g])) else $error("FAIL oe_we_overlap dut%0d", g);
      if (oe[g] && we[g]) overlap_cnt++;
      if (we[g] && (saddr[g] !== prev_addr[g])) addr_chg_cnt++;
      if (ce[g] && we[g]) mem[key(g, saddr[g])] = sdout[g];
      if (ce[g] && !prev_ce[g]) last_gap[g] = ce_low_run[g];
      ce_low_run[g] = ce[g] ? 0 : ce_low_run[g] + 1;
      prev_ce[g]    = ce[g];
      prev_addr[g]  = saddr[g];
      sdin[g] = (ce[g] && oe[g] && mem.exists(key(g, saddr[g]))) ? mem[key(g, saddr[g])] : '0;
    end
  end

  // Reference model: shadow of what each SRAM should hold
  logic [DW-1:0] ref_mem [logic [AW:0]];

  function automatic logic [DW-1:0] exp_rd(input int d, input logic [AW-1:0] a);
    return ref_mem.exists(key(d, a)) ? ref_mem[key(d, a)] : '0;
  endfunction

  int            n_pass  = 0;
  int            n_total = 0;
  int            r_lat, r_oe, r_we;
  bit            r_addr_ok, r_hold_ok, r_ack_low;
  logic          r_busy;
  logic [DW-1:0] r_rd;

  // One full handshake; results left in r_* for the calling test
  task automatic txn(input int d, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input bit scramble, input int hold);
    bit got_ack = 1'b0;
    rwm[d] = wr; adm[d] = a; dwm[d] = wd; rqm[d] = 1'b1;
    r_lat = 0; r_oe = 0; r_we = 0; r_addr_ok = 1'b1; r_hold_ok = 1'b1;
    while (!got_ack && r_lat < 40) begin
      @(posedge clk); r_lat++; @(negedge clk);
      if (scramble && r_lat == 1) begin
        adm[d] = '0; dwm[d] = '0; rwm[d] = !wr;
      end
      if (oe[d]) r_oe++;
      if (we[d]) r_we++;
      if (ce[d] && ((saddr[d] !== a) || (wr && sdout[d] !== wd))) r_addr_ok = 1'b0;
      if (akm[d]) got_ack = 1'b1;
    end
    if (!got_ack) r_lat = -1;
    r_rd = drm[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (akm[d] !== 1'b1 || ce[d] !== 1'b0 || busy[d] !== 1'b1) r_hold_ok = 1'b0;
    end
    rqm[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    r_ack_low = (akm[d] === 1'b0);
    r_busy    = busy[d];
    if (wr) ref_mem[key(d, a)] = wd;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rqm[d] = 1'b0; rwm[d] = 1'b0; adm[d] = '0; dwm[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({akm[d], busy[d], ce[d], oe[d], we[d]} !== 5'b0)
        $display("FAIL reset_ctrl dut%0d: got %b expected 00000", d, {akm[d], busy[d], ce[d], oe[d], we[d]});
      else n_pass++;
      n_total++;
      if ({saddr[d], sdout[d], drm[d]} !== '0)
        $display("FAIL reset_data dut%0d: got %h/%h/%h expected 0/0/0", d, saddr[d], sdout[d], drm[d]);
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    rwm[0] = 1'b1; adm[0] = 20'h0BAD0; dwm[0] = 16'h7777; rqm[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (we[0] !== 1'b1) $display("FAIL reset_pre_we: got %b expected 1", we[0]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ce[0], oe[0], we[0], akm[0]} !== 4'b0)
      $display("FAIL reset_midaccess: got %b expected 0000", {ce[0], oe[0], we[0], akm[0]});
    else n_pass++;
    rqm[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy[0], ce[0], akm[0]} !== 3'b0)
      $display("FAIL reset_release: got %b expected 000", {busy[0], ce[0], akm[0]});
    else n_pass++;
  endtask

  task automatic test_read();
    txn(0, 1'b1, 20'h12345, 16'hBEEF, 1'b0, 0);
    n_total++;
    if (r_lat !== 4 + ws_of(0)) $display("FAIL read_prewrite_lat: got %0d expected %0d", r_lat, 4 + ws_of(0));
    else n_pass++;
    txn(0, 1'b0, 20'h12345, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_lat !== 5) $display("FAIL read_lat: got %0d expected 5", r_lat);
    else n_pass++;
    n_total++;
    if (r_oe !== 4) $display("FAIL read_oe_cycles: got %0d expected 4", r_oe);
    else n_pass++;
    n_total++;
    if (r_rd !== 16'hBEEF) $display("FAIL read_data: got %h expected beef", r_rd);
    else n_pass++;
    n_total++;
    if (!r_addr_ok) $display("FAIL read_addr: got unstable expected 12345");
    else n_pass++;
    n_total++;
    if (!r_ack_low || r_busy !== 1'b0) $display("FAIL read_release: got ack_low=%0b busy=%b expected 1/0", r_ack_low, r_busy);
    else n_pass++;
  endtask

  task automatic test_write();
    txn(1, 1'b1, 20'hFFFFF, 16'h1234, 1'b0, 0);
    n_total++;
    if (r_lat !== 4) $display("FAIL write_lat: got %0d expected 4", r_lat);
    else n_pass++;
    n_total++;
    if (r_we !== 1) $display("FAIL write_we_cycles: got %0d expected 1", r_we);
    else n_pass++;
    n_total++;
    if (!r_addr_ok) $display("FAIL write_addr_dout: got unstable expected fffff/1234");
    else n_pass++;
    txn(1, 1'b0, 20'hFFFFF, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_rd !== 16'h1234 || r_lat !== 3) $display("FAIL write_readback: got %h lat %0d expected 1234 lat 3", r_rd, r_lat);
    else n_pass++;
  endtask

  task automatic test_field_stability();
    txn(0, 1'b1, 20'h00100, 16'hA5A5, 1'b1, 0);
    n_total++;
    if (!r_addr_ok) $display("FAIL stab_addr_dout: got changed expected 00100/a5a5");
    else n_pass++;
    n_total++;
    if (r_we !== ws_of(0) + 1 || r_lat !== 4 + ws_of(0))
      $display("FAIL stab_we_lat: got we %0d lat %0d expected %0d/%0d", r_we, r_lat, ws_of(0) + 1, 4 + ws_of(0));
    else n_pass++;
    txn(0, 1'b0, 20'h00100, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_rd !== 16'hA5A5) $display("FAIL stab_readback: got %h expected a5a5", r_rd);
    else n_pass++;
    txn(0, 1'b0, 20'h00000, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_rd !== exp_rd(0, 20'h00000)) $display("FAIL stab_addr0: got %h expected %h", r_rd, exp_rd(0, 20'h00000));
    else n_pass++;
  endtask

  task automatic test_abandon();
    bit akm_seen = 1'b0;
    bit idle_seen = 1'b0;
    rwm[0] = 1'b1; adm[0] = 20'h00300; dwm[0] = 16'hCAFE; rqm[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rqm[0] = 1'b0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      @(posedge clk); @(negedge clk);
      if (akm[0]) akm_seen = 1'b1;
      if (!busy[0]) idle_seen = 1'b1;
    end
    ref_mem[key(0, 20'h00300)] = 16'hCAFE;
    n_total++;
    if (akm_seen) $display("FAIL abandon_ack: got akm 1 expected 0");
    else n_pass++;
    n_total++;
    if (!idle_seen) $display("FAIL abandon_busy: got busy stuck 1 expected 0");
    else n_pass++;
    txn(0, 1'b0, 20'h00300, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_rd !== 16'hCAFE || r_lat !== 3 + ws_of(0))
      $display("FAIL abandon_next: got %h lat %0d expected cafe lat %0d", r_rd, r_lat, 3 + ws_of(0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    txn(1, 1'b1, 20'h00777, 16'h5A5A, 1'b0, 6);
    n_total++;
    if (!r_hold_ok) $display("FAIL b2b_hold: got retrigger or ack drop expected ack held, no access");
    else n_pass++;
    txn(1, 1'b0, 20'h00777, 16'h0000, 1'b0, 0);
    n_total++;
    if (r_rd !== 16'h5A5A || r_lat !== 3) $display("FAIL b2b_second: got %h lat %0d expected 5a5a lat 3", r_rd, r_lat);
    else n_pass++;
    n_total++;
    if (last_gap[1] < 2) $display("FAIL b2b_ce_gap: got %0d expected >=2", last_gap[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int            d  = int'($urandom_range(0, 1));
      bit            wr = bit'($urandom_range(0, 1));
      logic [AW-1:0] a  = 20'h00400 + AW'($urandom_range(0, 7));
      logic [DW-1:0] wd = DW'($urandom);
      logic [DW-1:0] ex = exp_rd(d, a);
      txn(d, wr, a, wd, bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      n_total++;
      if (r_lat !== (wr ? 4 : 3) + ws_of(d))
        $display("FAIL rand_lat #%0d dut%0d: got %0d expected %0d", n, d, r_lat, (wr ? 4 : 3) + ws_of(d));
      else n_pass++;
      if (!wr) begin
        n_total++;
        if (r_rd !== ex) $display("FAIL rand_rd #%0d dut%0d @%h: got %h expected %h", n, d, a, r_rd, ex);
        else n_pass++;
      end
      if (!r_addr_ok || !r_hold_ok) begin
        n_total++;
        $display("FAIL rand_pins #%0d dut%0d: got addr_ok=%0b hold_ok=%0b expected 1/1", n, d, r_addr_ok, r_hold_ok);
      end
    end
  endtask

  task automatic test_strobe_rules();
    n_total++;
    if (overlap_cnt !== 0) $display("FAIL oe_we_overlap_count: got %0d expected 0", overlap_cnt);
    else n_pass++;
    n_total++;
    if (addr_chg_cnt !== 0) $display("FAIL we_addr_change: got %0d expected 0", addr_chg_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_field_stability();
    test_abandon();
    test_back_to_back();
    test_random();
    test_strobe_rules();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
